// File: rtl/multilane_pkg.sv
// Shared constants and width helpers for the multi-lane virtual-channel FIFO.
package multilane_pkg;

    localparam int DEF_LANES      = 4;
    localparam int DEF_DEPTH_BITS = 2;
    localparam int DEF_DATA_WIDTH = 32;

    // Width of a lane index (LANES is at least 2, so this is never zero)
    function automatic int lane_bits(input int lanes);
        return $clog2(lanes);
    endfunction

    // Occupancy counter width: must hold 0..DEPTH inclusive
    function automatic int count_bits(input int depth_bits);
        return depth_bits + 1;
    endfunction

endpackage

// File: rtl/vc_lane_ctrl.sv
// Pointer, occupancy and status bookkeeping for one lane of the FIFO.
// The top level has already decided which operations are accepted.
module vc_lane_ctrl #(
    parameter int DEPTH_BITS  = 2,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_en,
    input  logic                  pop_en,
    output logic [DEPTH_BITS-1:0] wr_ptr,
    output logic [DEPTH_BITS-1:0] rd_ptr,
    output logic [DEPTH_BITS:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  credit
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  credit_q, credit_d;

    // Next-state: pointers wrap naturally, count only moves on push-xor-pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        credit_d = pop_en;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (DEPTH_BITS+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State register; reset empties the lane immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

    assign wr_ptr      = wr_ptr_q;
    assign rd_ptr      = rd_ptr_q;
    assign count       = count_q;
    assign credit      = credit_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == (DEPTH_BITS+1)'(DEPTH));
    assign almost_full = (count_q >= (DEPTH_BITS+1)'(AFULL_LEVEL));

endmodule

// File: rtl/multilane_vc_fifo.sv
// Multi-lane virtual-channel FIFO: LANES independent first-word-fall-through
// queues sharing one storage array, one push port and one pop port.
module multilane_vc_fifo
    import multilane_pkg::*;
#(
    parameter  int LANES       = DEF_LANES,
    parameter  int DEPTH_BITS  = DEF_DEPTH_BITS,
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int AFULL_LEVEL = (1 << DEPTH_BITS) - 1,
    localparam int LANE_BITS   = lane_bits(LANES),
    localparam int CNT_W       = count_bits(DEPTH_BITS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [LANE_BITS-1:0]   push_lane,
    input  logic                   pop,
    input  logic [LANE_BITS-1:0]   pop_lane,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic [LANES-1:0]       empty,
    output logic [LANES-1:0]       full,
    output logic [LANES-1:0]       almost_full,
    output logic [LANES*CNT_W-1:0] count,
    output logic [LANES-1:0]       credit,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [DATA_WIDTH-1:0] mem_q [LANES][DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr [LANES];
    logic [DEPTH_BITS-1:0] rd_ptr [LANES];
    logic [LANES-1:0]      push_en;
    logic [LANES-1:0]      pop_en;
    logic                  push_in_range, pop_in_range;
    logic                  push_ok, pop_ok;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    // Acceptance: a full lane still takes a push if the same lane pops this cycle
    always_comb begin
        push_in_range = (int'(push_lane) < LANES);
        pop_in_range  = (int'(pop_lane) < LANES);
        pop_ok        = pop && pop_in_range && !empty[pop_lane];
        push_ok       = push && push_in_range &&
                        (!full[push_lane] || (pop_ok && (pop_lane == push_lane)));
        push_en       = '0;
        pop_en        = '0;
        if (push_ok) begin
            push_en[push_lane] = 1'b1;
        end
        if (pop_ok) begin
            pop_en[pop_lane] = 1'b1;
        end
    end

    // Per-lane pointer, count and status logic
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vc_lane_ctrl #(
            .DEPTH_BITS  (DEPTH_BITS),
            .AFULL_LEVEL (AFULL_LEVEL)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .push_en     (push_en[i]),
            .pop_en      (pop_en[i]),
            .wr_ptr      (wr_ptr[i]),
            .rd_ptr      (rd_ptr[i]),
            .count       (count[i*CNT_W +: CNT_W]),
            .empty       (empty[i]),
            .full        (full[i]),
            .almost_full (almost_full[i]),
            .credit      (credit[i])
        );
    end

    // Storage write; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[push_lane][wr_ptr[push_lane]] <= din;
        end
    end

    // Fall-through read of the selected lane's head word
    always_comb begin
        dout = '0;
        if (pop_in_range) begin
            dout = mem_q[pop_lane][rd_ptr[pop_lane]];
        end
    end

    // Sticky error flags accumulate any rejected request
    always_comb begin
        overflow_d  = overflow_q  | (push & ~push_ok);
        underflow_d = underflow_q | (pop & ~pop_ok);
    end

    // Error flag registers, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_multilane_vc_fifo.sv
// Self-checking bench for multilane_vc_fifo with two lanes of depth four.
// Stimulus pushes expected pop data into a scoreboard; a negedge monitor
// compares dout whenever the DUT presents a word for an issued pop.
module tb_multilane_vc_fifo;

   typedef struct {
      logic        lane;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        push;
   logic        push_lane;
   logic        pop;
   logic        pop_lane;
   logic [31:0] din;
   logic [31:0] dout;
   logic [1:0]  empty;
   logic [1:0]  full;
   logic [1:0]  almost_full;
   logic [5:0]  count;
   logic [1:0]  credit;
   logic        overflow_err;
   logic        underflow_err;

   int          checks;
   int          passes;
   exp_t        expQ[$];
   logic [31:0] mq [2][$];
   logic        expOvf;
   logic        expUnf;

   multilane_vc_fifo #(
      .LANES      (2),
      .DEPTH_BITS (2),
      .DATA_WIDTH (32)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .push          (push),
      .push_lane     (push_lane),
      .pop           (pop),
      .pop_lane      (pop_lane),
      .din           (din),
      .dout          (dout),
      .empty         (empty),
      .full          (full),
      .almost_full   (almost_full),
      .count         (count),
      .credit        (credit),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // One comparison: counts it and reports any difference
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare every status output against the model's view of both lanes
   task automatic checkStatus(input logic [1:0] expCredit);
      logic [1:0] eEmpty, eFull, eAfull;
      logic [5:0] eCount;
      for (int l = 0; l < 2; l++) begin
         eEmpty[l] = (mq[l].size() == 0);
         eFull[l]  = (mq[l].size() == 4);
         eAfull[l] = (mq[l].size() >= 3);
         eCount[l*3 +: 3] = 3'(mq[l].size());
      end
      checkOutput("empty", 32'(empty), 32'(eEmpty));
      checkOutput("full", 32'(full), 32'(eFull));
      checkOutput("almost_full", 32'(almost_full), 32'(eAfull));
      checkOutput("count", 32'(count), 32'(eCount));
      checkOutput("credit", 32'(credit), 32'(expCredit));
      checkOutput("overflow_err", 32'(overflow_err), 32'(expOvf));
      checkOutput("underflow_err", 32'(underflow_err), 32'(expUnf));
   endtask

   // Drive one cycle of requests, predict the outcome, then check after the edge
   task automatic applyStimulus(input logic ps, input logic pl, input logic [31:0] d,
                                input logic pp, input logic ppl);
      logic       popAcc, pushAcc;
      logic [1:0] expCredit;
      exp_t       e;
      push      = ps;
      push_lane = pl;
      din       = d;
      pop       = pp;
      pop_lane  = ppl;
      popAcc    = pp && (mq[ppl].size() > 0);
      pushAcc   = ps && ((mq[pl].size() < 4) || (popAcc && (ppl == pl)));
      expCredit = 2'b00;
      if (popAcc) begin
         e.lane = ppl;
         e.data = mq[ppl][0];
         expQ.push_back(e);
         void'(mq[ppl].pop_front());
         expCredit[ppl] = 1'b1;
      end
      if (pushAcc) begin
         mq[pl].push_back(d);
      end
      if (ps && !pushAcc) expOvf = 1'b1;
      if (pp && !popAcc) expUnf = 1'b1;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
      checkStatus(expCredit);
   endtask

   // Monitor: whenever the DUT presents a word for a pop, compare it with the scoreboard
   always @(negedge clk) begin
      if (reset && pop && !empty[pop_lane]) begin
         if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL dout: unexpected word 0x%0h on lane %0d, expected none", dout, pop_lane);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("pop_lane", 32'(pop_lane), 32'(e.lane));
            checkOutput("dout", dout, e.data);
         end
      end
   end

   initial begin
      reset     = 1'b0;
      push      = 1'b0;
      push_lane = 1'b0;
      pop       = 1'b0;
      pop_lane  = 1'b0;
      din       = '0;
      checks    = 0;
      passes    = 0;
      expOvf    = 1'b0;
      expUnf    = 1'b0;

      // Reset state
      #1;
      checkStatus(2'b00);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Mid-cycle asynchronous reset after three pushes and a pop
      applyStimulus(1'b1, 1'b0, 32'd10, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'd11, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'd12, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_reset_empty", 32'(empty), 32'h3);
      checkOutput("async_reset_count", 32'(count), 32'h0);
      checkOutput("async_reset_credit", 32'(credit), 32'h0);
      mq[0].delete();
      mq[1].delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkStatus(2'b00);

      // Fill lane 0; almost_full appears at three words
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 1'b0, 32'(i), 1'b0, 1'b0);
      end

      // Overflow on a full lane, then drain in order
      applyStimulus(1'b1, 1'b0, 32'd99, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      end

      // Simultaneous push and pop on a full lane
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 1'b0, 32'(i), 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 32'd5, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      end

      // Cross-lane traffic wrapping the pointers several times
      applyStimulus(1'b1, 1'b0, 32'd50, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'd51, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b1, 32'(100 + i), 1'b1, 1'b0);
         applyStimulus(1'b1, 1'b0, 32'(200 + i), 1'b1, 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

      // Pop of the empty lane 1
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/multilane_vc_fifo.md
MULTILANE_VC_FIFO -- requirements
Module: multilane_vc_fifo

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent lanes (virtual channels), minimum 2.
REQ-002 SHALL have parameter DEPTH_BITS, default 2: log2 of per-lane depth; DEPTH = 2**DEPTH_BITS.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-004 SHALL have parameter AFULL_LEVEL, default DEPTH-1: occupancy at or above which almost_full asserts.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports push, input, 1 and push_lane, input, LANE_BITS=$clog2(LANES): write request and target lane.
REQ-008 SHALL have ports pop, input, 1 and pop_lane, input, LANE_BITS: read request and source lane.
REQ-009 SHALL have port din, input, DATA_WIDTH: write data.
REQ-010 SHALL have port dout, output, DATA_WIDTH: head word of pop_lane, first-word-fall-through.
REQ-011 SHALL have ports empty, full, almost_full, output, LANES each: per-lane status.
REQ-012 SHALL have port count, output, LANES*(DEPTH_BITS+1): packed per-lane occupancy, lane 0 in the LSBs.
REQ-013 SHALL have port credit, output, LANES: one-cycle pulse per accepted pop, per lane.
REQ-014 SHALL have ports overflow_err and underflow_err, output, 1: sticky error flags.

Function
REQ-015 Each lane SHALL be an independent FIFO of DEPTH words, with its own read pointer, write pointer and occupancy counter.
REQ-016 push SHALL be accepted when !full[push_lane], or when full[push_lane] and pop && pop_lane==push_lane in the same cycle.
REQ-017 pop SHALL be accepted when !empty[pop_lane].
REQ-018 A push and a pop to different lanes SHALL both complete in one cycle; each lane's count changes by +1 or -1 respectively.
REQ-019 A push and a pop to the same lane SHALL leave that lane's count unchanged and advance both pointers.
REQ-020 dout SHALL combinationally present mem[pop_lane][rd_ptr] whenever !empty[pop_lane]; when empty its value is don't-care.
REQ-021 Written data SHALL become visible on dout the cycle after the push edge; zero added read latency.
REQ-022 Pointers SHALL be DEPTH_BITS wide and wrap modulo DEPTH; the count SHALL be DEPTH_BITS+1 wide, range 0..DEPTH.
REQ-023 The status outputs SHALL be registered or derived directly from count: empty=(count==0), full=(count==DEPTH), almost_full=(count>=AFULL_LEVEL).
REQ-024 credit[pop_lane] SHALL pulse high for exactly the cycle after an accepted pop; all other bits low.
REQ-025 A rejected push SHALL set overflow_err and leave storage, pointers and count unchanged.
REQ-026 A rejected pop SHALL set underflow_err and leave state unchanged.
REQ-027 The error flags SHALL clear only on reset.
REQ-028 A push_lane or pop_lane value >= LANES SHALL be treated as rejected and SHALL set the corresponding error flag.

Reset
REQ-029 While reset==0, the block SHALL asynchronously clear all pointers and counts, with empty all-ones, full=0, almost_full=0, credit=0 and error flags 0.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all queued data immediately, without waiting for a clock edge.

Structure
REQ-032 A shared package multilane_pkg SHALL hold the lane-index and count width functions and the default parameter constants.
REQ-033 The per-lane pointer/count/status logic SHALL be one sub-module, vc_lane_ctrl, instantiated LANES times by a generate loop.
REQ-034 Storage SHALL be a single 2-D array indexed [lane][ptr] in the top level.

Verification (LANES=2, DEPTH_BITS=2, DATA_WIDTH=32)
REQ-035 Assert reset low mid-cycle after 3 pushes -> empty=2'b11, count=0 and credit=0 before the next clk edge.
REQ-036 Push 1..4 to lane 0 -> full[0]=1, count lane0=4, almost_full[0] set at count 3, empty[1]=1.
REQ-037 Push 99 to full lane 0 -> overflow_err=1; then pop 4 times -> dout sequence 1,2,3,4; credit[0] pulses 4 times; empty[0]=1.
REQ-038 Lane 0 full; push 5 to lane 0 while popping lane 0 -> accepted, count stays 4, no overflow; subsequent pops yield 2,3,4,5.
REQ-039 Push lane 1 and pop lane 0 in the same cycle for 10 cycles with wrap -> order preserved on both lanes; pop of empty lane 1 sets underflow_err.
